// File: rtl/gol_controller.sv
// Sequencing controller for an 8x8 Game of Life engine: owns the current grid and
// generation counter, and decides each cycle whether the external datapath result is taken.
module gol_controller #(
  parameter int GEN_W          = 16,
  parameter bit STOP_ON_STABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic [GEN_W-1:0] gen_limit,
  input  logic [63:0]      next_grid,
  output logic [63:0]      cur_grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic             extinct
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  state_t           start_target;
  logic [GEN_W-1:0] lim_q;
  logic [GEN_W:0]   gen_inc;
  logic             is_empty;
  logic             is_still;
  logic             at_limit;
  logic             lim_hit;
  logic             evolve;
  logic             do_load;
  logic             do_start;
  logic             do_adv;
  logic             set_ext;
  logic             set_stb;

  // Compare in GEN_W+1 bits so the incremented count can never wrap past the limit.
  function automatic logic reached(input logic [GEN_W:0] cnt, input logic [GEN_W-1:0] lim);
    return cnt >= {1'b0, lim};
  endfunction

  assign gen_inc      = {1'b0, gen_count} + {{GEN_W{1'b0}}, 1'b1};
  assign is_empty     = (cur_grid == '0);
  assign is_still     = STOP_ON_STABLE && (next_grid == cur_grid);
  assign at_limit     = reached({1'b0, gen_count}, lim_q);
  assign lim_hit      = reached(gen_inc, lim_q);
  assign start_target = reached({1'b0, gen_count}, gen_limit) ? S_DONE : S_RUN;

  // A single generation is attempted free-running in RUN, or once per step while paused.
  assign evolve = ((state == S_RUN) && !pause) ||
                  ((state == S_PAUSED) && step && !load && !start && !at_limit);

  always_comb begin
    state_d  = state;
    do_load  = 1'b0;
    do_start = 1'b0;
    do_adv   = 1'b0;
    set_ext  = 1'b0;
    set_stb  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (load) begin
          do_load = 1'b1;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (load) begin
          do_load = 1'b1;
          state_d = S_LOADED;
        end else if (start) begin
          do_start = 1'b1;
          state_d  = start_target;
        end
      end
      S_PAUSED: begin
        if (load) begin
          do_load = 1'b1;
          state_d = S_LOADED;
        end else if (start) begin
          do_start = 1'b1;
          state_d  = start_target;
        end else if (step && at_limit) begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (pause) begin
          state_d = S_PAUSED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (evolve) begin
      if (is_empty) begin
        set_ext = 1'b1;
        state_d = S_DONE;
      end else if (is_still) begin
        set_stb = 1'b1;
        state_d = S_DONE;
      end else begin
        do_adv = 1'b1;
        if (lim_hit) begin
          state_d = S_DONE;
        end
      end
    end
  end

  // Registered state, grid, counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_grid  <= '0;
      gen_count <= '0;
      lim_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == S_RUN);
      done  <= (state_d == S_DONE);
      if (do_load) begin
        cur_grid  <= seed;
        gen_count <= '0;
        stable    <= 1'b0;
        extinct   <= 1'b0;
      end
      if (do_start) begin
        lim_q <= gen_limit;
      end
      if (do_adv) begin
        cur_grid  <= next_grid;
        gen_count <= gen_inc[GEN_W-1:0];
      end
      if (set_ext) begin
        extinct <= 1'b1;
      end
      if (set_stb) begin
        stable <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gol_controller.sv
// Scoreboard bench for gol_controller: a behavioural model predicts every cycle's outputs,
// and a monitor compares them against the DUT after each clock or reset edge.
module tb_gol_controller;
  localparam int          GEN_W   = 16;
  localparam logic [63:0] BLINK_A = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINK_B = 64'h0000_0010_1010_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load, start, pause, step;
  logic [63:0]      seed;
  logic [63:0]      next_grid;
  logic [63:0]      cur_grid;
  logic [GEN_W-1:0] gen_limit;
  logic [GEN_W-1:0] gen_count;
  logic             busy, done, stable, extinct;
  int               rule;  // 0 blinker toggle, 1 frozen grid, 2 real Life

  typedef struct {
    logic [63:0] cur;
    int          gen;
    logic        busy;
    logic        done;
    logic        stb;
    logic        ext;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_mode, m_gen, m_lim;
  logic [63:0] m_cur;
  logic        m_stb, m_ext;

  gol_controller #(.GEN_W(GEN_W), .STOP_ON_STABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .start(start), .pause(pause),
    .step(step), .gen_limit(gen_limit), .next_grid(next_grid), .cur_grid(cur_grid),
    .gen_count(gen_count), .busy(busy), .done(done), .stable(stable), .extinct(extinct)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int          cnt, rr, cc, idx;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
              idx = rr * 8 + cc;
              if (g[idx[5:0]]) cnt++;
            end
          end
        end
        idx = r * 8 + c;
        n[idx[5:0]] = (cnt == 3) || (cnt == 2 && g[idx[5:0]]);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] grid_next(input int rl, input logic [63:0] g);
    if (rl == 0) return (g == BLINK_A) ? BLINK_B : ((g == BLINK_B) ? BLINK_A : g);
    if (rl == 1) return g;
    return life(g);
  endfunction

  assign next_grid = grid_next(rule, cur_grid);

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cur  = '0;
    m_gen  = 0;
    m_lim  = 0;
    m_stb  = 1'b0;
    m_ext  = 1'b0;
  endtask

  task automatic model_evolve(input logic [63:0] nx);
    if (m_cur == 64'd0) begin
      m_ext  = 1'b1;
      m_mode = M_DONE;
    end else if (nx == m_cur) begin
      m_stb  = 1'b1;
      m_mode = M_DONE;
    end else begin
      m_cur = nx;
      m_gen = m_gen + 1;
      if (m_gen >= m_lim) m_mode = M_DONE;
    end
  endtask

  task automatic model_edge(input logic ld, input logic st, input logic ps, input logic sp,
                            input logic [63:0] sd, input int gl);
    logic [63:0] nx;
    nx = grid_next(rule, m_cur);
    if (ld && m_mode != M_RUN) begin
      m_cur  = sd;
      m_gen  = 0;
      m_stb  = 1'b0;
      m_ext  = 1'b0;
      m_mode = M_LOADED;
    end else if (m_mode == M_RUN) begin
      if (ps) m_mode = M_PAUSED;
      else model_evolve(nx);
    end else if ((m_mode == M_LOADED || m_mode == M_PAUSED) && st) begin
      m_lim  = gl;
      m_mode = (m_gen >= gl) ? M_DONE : M_RUN;
    end else if (m_mode == M_PAUSED && sp) begin
      if (m_gen >= m_lim) m_mode = M_DONE;
      else model_evolve(nx);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cur  = m_cur;
    e.gen  = m_gen;
    e.busy = (m_mode == M_RUN);
    e.done = (m_mode == M_DONE);
    e.stb  = m_stb;
    e.ext  = m_ext;
    sb.push_back(e);
  endtask

  task automatic tick(input logic ld, input logic st, input logic ps, input logic sp,
                      input logic [63:0] sd, input int gl);
    load      = ld;
    start     = st;
    pause     = ps;
    step      = sp;
    seed      = sd;
    gen_limit = gl[GEN_W-1:0];
    model_edge(ld, st, ps, sp, sd, gl);
    push_exp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, seed, int'($urandom_range(0, 200)));
  endtask

  task automatic clear_inputs();
    load      = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    step      = 1'b0;
    seed      = '0;
    gen_limit = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    model_reset();
    push_exp();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    clear_inputs();
    model_reset();
    push_exp();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic logic [63:0] pick_seed();
    case ($urandom_range(0, 4))
      0: return {$urandom() & $urandom(), $urandom() & $urandom()};
      1: return {$urandom(), $urandom()};
      2: return 64'd0;
      3: return BLOCK;
      default: return BLINK_A;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (cur_grid !== e.cur || int'(gen_count) != e.gen || busy !== e.busy ||
            done !== e.done || stable !== e.stb || extinct !== e.ext) begin
          errors++;
          $display("FAIL sb @%0t: got cur=%h gen=%0d busy=%b done=%b stable=%b extinct=%b; expected cur=%h gen=%0d busy=%b done=%b stable=%b extinct=%b",
                   $time, cur_grid, gen_count, busy, done, stable, extinct,
                   e.cur, e.gen, e.busy, e.done, e.stb, e.ext);
        end
      end
    end
  end

  initial begin : driver
    logic ld, st, ps, sp;
    rule = 0;
    apply_reset();

    // Inputs other than load are ignored in IDLE; pause/step are ignored in LOADED.
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 3);
    tick(1'b0, 1'b0, 1'b1, 1'b1, '0, 3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLINK_A, 3);
    tick(1'b0, 1'b0, 1'b1, 1'b1, '0, 3);

    // Blinker for five generations.
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLINK_A, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 5);
    idle(5);
    expect_now("blink5_done", done, 1);
    expect_now("blink5_gen", gen_count, 5);
    expect_now("blink5_grid", cur_grid, BLINK_B);
    expect_now("blink5_stable", stable, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, '0, 50);
    idle(2);

    // Still life ends the run without advancing.
    rule = 1;
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLOCK, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLOCK, 100);
    idle(1);
    expect_now("still_done", done, 1);
    expect_now("still_gen", gen_count, 0);
    expect_now("still_stable", stable, 1);
    expect_now("still_extinct", extinct, 0);

    // Empty grid ends the run as extinct.
    rule = 2;
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 10);
    idle(1);
    expect_now("empty_done", done, 1);
    expect_now("empty_extinct", extinct, 1);
    expect_now("empty_gen", gen_count, 0);

    // Pause, single steps, then resume to the limit.
    rule = 0;
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLINK_A, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 10);
    idle(3);
    tick(1'b0, 1'b0, 1'b1, 1'b0, BLINK_A, 10);
    idle(2);
    expect_now("pause_gen", gen_count, 3);
    expect_now("pause_busy", busy, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, BLINK_A, 10);
    expect_now("step1_gen", gen_count, 4);
    tick(1'b0, 1'b0, 1'b0, 1'b1, BLINK_A, 10);
    expect_now("step2_gen", gen_count, 5);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 10);
    idle(4);
    expect_now("resume_notdone", done, 0);
    idle(1);
    expect_now("resume_done", done, 1);
    expect_now("resume_gen", gen_count, 10);

    // Load beats start; a zero limit finishes immediately.
    apply_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, BLINK_A, 5);
    expect_now("ldst_busy", busy, 0);
    expect_now("ldst_grid", cur_grid, BLINK_A);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 0);
    expect_now("lim0_done", done, 1);
    expect_now("lim0_gen", gen_count, 0);

    // Load ignored in RUN, then asynchronous reset mid-run and a clean restart.
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLINK_A, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 10);
    idle(2);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 10);
    idle(1);
    expect_now("midrun_gen", gen_count, 4);
    async_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, BLINK_A, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLINK_A, 3);
    idle(3);
    expect_now("restart_done", done, 1);
    expect_now("restart_grid", cur_grid, BLINK_B);

    // Randomized control traffic over real Life evolution.
    rule = 2;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        ld = ($urandom_range(0, 99) < 8);
        st = ($urandom_range(0, 99) < 15);
        ps = ($urandom_range(0, 99) < 10);
        sp = ($urandom_range(0, 99) < 25);
        tick(ld, st, ps, sp, pick_seed(), int'($urandom_range(0, 15)));
      end
    end

    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gol_controller.md
GOL_CONTROLLER -- requirements
Module: gol_controller

Interface
REQ-001 SHALL have parameter GEN_W, default 16, the width of the generation counter and limit.
REQ-002 SHALL have parameter STOP_ON_STABLE, default 1; when 1, a still-life grid terminates the run.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port seed  input  64  the initial 8x8 grid, captured on load.
REQ-006 SHALL have port load  input  1  the request to capture seed.
REQ-007 SHALL have port start  input  1  the request to begin or resume free-running evolution.
REQ-008 SHALL have port pause  input  1  the request to halt evolution while running.
REQ-009 SHALL have port step  input  1  the request to advance exactly one generation while paused.
REQ-010 SHALL have port gen_limit  input  GEN_W  the number of generations to run, sampled on start.
REQ-011 SHALL have port next_grid  input  64  the combinational next generation of cur_grid, from the external datapath.
REQ-012 SHALL have port cur_grid  output  64  the registered current grid, driving the datapath input.
REQ-013 SHALL have port gen_count  output  GEN_W  the number of generations applied since the last load.
REQ-014 SHALL have port busy  output  1  high in RUN only.
REQ-015 SHALL have port done  output  1  high in DONE only.
REQ-016 SHALL have port stable  output  1  sticky flag: the run ended on a still life.
REQ-017 SHALL have port extinct  output  1  sticky flag: the run ended on an empty grid.

Function
REQ-018 SHALL implement the states IDLE, LOADED, RUN, PAUSED and DONE; the state encoding is internal.
REQ-019 In IDLE, LOADED, PAUSED or DONE, load SHALL set cur_grid to seed, gen_count to 0 and clear stable and extinct, with next state LOADED; load SHALL be ignored in RUN.
REQ-020 load SHALL take priority over start, step and pause in the same cycle.
REQ-021 In LOADED or PAUSED, start SHALL register gen_limit into lim_q and enter RUN, or enter DONE directly if gen_count >= gen_limit.
REQ-022 An "advance" SHALL perform cur_grid <= next_grid and gen_count <= gen_count+1, both in one cycle.
REQ-023 RUN SHALL evaluate the following checks each cycle in this priority order:
  - pause -> PAUSED, with no advance.
  - cur_grid==0 -> DONE, extinct=1, no advance.
  - STOP_ON_STABLE and next_grid==cur_grid -> DONE, stable=1, no advance.
  - Otherwise advance; if gen_count+1 >= lim_q -> DONE.
REQ-024 In PAUSED, step (without start or load) SHALL perform the REQ-023 extinct, stable and limit checks, advance at most once, and remain PAUSED unless a check sends it to DONE.
REQ-025 A step asserted for N consecutive cycles SHALL produce N advances, one per cycle.
REQ-026 start, step and pause in IDLE, and pause and step in LOADED, SHALL be ignored; DONE SHALL exit only via load or reset.
REQ-027 After the cycle in which start is sampled, changes on gen_limit SHALL have no effect.
REQ-028 gen_count SHALL never exceed lim_q and SHALL never wrap; a step in PAUSED with gen_count >= lim_q SHALL go to DONE without advancing.
REQ-029 Latency: start-to-first-advance SHALL be 1 cycle, and the cur_grid update SHALL be visible the cycle after each advance.

Reset
REQ-030 Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, cur_grid=0, gen_count=0, lim_q=0, and busy, done, stable and extinct all 0.
REQ-031 The first edge after reset deasserts SHALL evaluate the inputs normally.

Verification
REQ-032 Bench model next_grid = blinker toggle (64'h0000_0000_0038_0000 <-> 64'h0000_0010_1010_0000); load the first, gen_limit=5, start -> busy for 5 cycles, then done=1, gen_count=5, cur_grid=64'h0000_0010_1010_0000, stable=0.
REQ-033 Model next_grid=cur_grid, seed=64'h0000_0018_1800_0000, gen_limit=100, start -> done the cycle after start, gen_count=0, stable=1, extinct=0.
REQ-034 Seed=0, gen_limit=10, start -> done=1, extinct=1, gen_count=0.
REQ-035 Blinker, gen_limit=10; pause after 3 advances, step x2, start -> gen_count freezes at 3 during pause, then shows 4 and 5, and done arrives at gen_count=10.
REQ-036 Load and start asserted in the same cycle -> LOADED, busy=0; gen_limit=0 with start -> DONE immediately, gen_count=0.
REQ-037 Reset asserted mid-RUN at gen_count=4 -> all outputs are 0 in the same cycle (asynchronously), and a subsequent load and start runs normally.
